// File: rtl/paralelo_serie_tx.sv
// Parallel-to-serial transmitter: sends a comma preamble after reset, then
// serializes user bytes MSB-first, filling empty byte slots with the idle symbol.
module paralelo_serie_tx #(
    parameter int          BC_COUNT = 4,
    parameter logic [7:0]  IDLE_SYM = 8'hBC
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       resync,
    output logic       data_out,
    output logic       data_ready,
    output logic       active,
    output logic       sending_data,
    output logic       sym_start
);

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [3:0] SYNC_LAST = 4'(BC_COUNT - 1);

    state_t     state;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic [7:0] cur_byte;
    logic       cur_is_data;
    logic       slot_end;
    logic       accept;

    assign slot_end = (bit_cnt == 3'd7);

    // The last comma boundary already accepts a byte so data can follow the
    // preamble without an extra idle slot.
    assign data_ready = slot_end && !resync &&
                        ((state == ACTIVE) || (sync_cnt == SYNC_LAST));
    assign accept     = data_ready && valid_in;

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            bit_cnt      <= 3'd0;
            sync_cnt     <= 4'd0;
            state        <= SYNC;
            cur_byte     <= IDLE_SYM;
            cur_is_data  <= 1'b0;
            data_out     <= 1'b0;
            active       <= 1'b0;
            sending_data <= 1'b0;
            sym_start    <= 1'b0;
        end else begin
            data_out     <= cur_byte[3'd7 - bit_cnt];
            sym_start    <= (bit_cnt == 3'd0);
            sending_data <= cur_is_data;
            active       <= (state == ACTIVE);
            bit_cnt      <= bit_cnt + 3'd1;

            // Slot contents and state only change on the last bit, so a slot
            // in flight is never cut short by resync.
            if (slot_end) begin
                cur_byte    <= IDLE_SYM;
                cur_is_data <= 1'b0;
                if (resync) begin
                    state    <= SYNC;
                    sync_cnt <= 4'd0;
                end else if (state == SYNC) begin
                    if (sync_cnt == SYNC_LAST) begin
                        state    <= ACTIVE;
                        sync_cnt <= 4'd0;
                    end else begin
                        sync_cnt <= sync_cnt + 4'd1;
                    end
                end
                if (accept) begin
                    cur_byte    <= data_in;
                    cur_is_data <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Bench for paralelo_serie_tx: slot-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_paralelo_serie_tx;

    localparam int         BC   = 4;
    localparam logic [7:0] IDLE = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       resync = 1'b0;
    logic       data_out;
    logic       data_ready;
    logic       active;
    logic       sending_data;
    logic       sym_start;

    int checks = 0;
    int errors = 0;

    paralelo_serie_tx #(.BC_COUNT(BC), .IDLE_SYM(IDLE)) dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .resync      (resync),
        .data_out    (data_out),
        .data_ready  (data_ready),
        .active      (active),
        .sending_data(sending_data),
        .sym_start   (sym_start)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        logic [7:0] sym;
        logic       is_data;
        logic       act;
    } slot_t;

    // Model: one slot at a time; commas counts comma slots of the current preamble.
    slot_t slot;
    int    commas;
    int    edge_cnt;
    int    first_ready;
    int    pos;
    logic  [2:0] bit_idx;
    logic  exp_do, exp_sym, exp_sd, exp_act, exp_rdy;
    logic  cap_do  [0:1023];
    logic  cap_sd  [0:1023];
    logic  cap_act [0:1023];
    logic  cap_sym [0:1023];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at t=%0t edge=%0d: got %0h expected %0h", name, $time, edge_cnt, actual, expected);
        end
    endtask

    task automatic model_reset();
        slot        = '{IDLE, 1'b0, 1'b0};
        commas      = 1;
        edge_cnt    = 0;
        first_ready = -1;
        exp_do      = 1'b0;
        exp_sym     = 1'b0;
        exp_sd      = 1'b0;
        exp_act     = 1'b0;
    endtask

    always @(negedge clk_8f) begin
        if (!reset) begin
            checkOutput("rst_data_out", {31'd0, data_out}, 32'd0);
            checkOutput("rst_active", {31'd0, active}, 32'd0);
            checkOutput("rst_sending_data", {31'd0, sending_data}, 32'd0);
            checkOutput("rst_sym_start", {31'd0, sym_start}, 32'd0);
            checkOutput("rst_data_ready", {31'd0, data_ready}, 32'd0);
            model_reset();
        end else begin
            checkOutput("data_out", {31'd0, data_out}, {31'd0, exp_do});
            checkOutput("sym_start", {31'd0, sym_start}, {31'd0, exp_sym});
            checkOutput("sending_data", {31'd0, sending_data}, {31'd0, exp_sd});
            checkOutput("active", {31'd0, active}, {31'd0, exp_act});
            if (edge_cnt > 0 && edge_cnt < 1024) begin
                cap_do[edge_cnt]  = data_out;
                cap_sd[edge_cnt]  = sending_data;
                cap_act[edge_cnt] = active;
                cap_sym[edge_cnt] = sym_start;
            end
            pos     = edge_cnt % 8;
            exp_rdy = (pos == 7) && !resync && (commas >= BC);
            checkOutput("data_ready", {31'd0, data_ready}, {31'd0, exp_rdy});
            if (exp_rdy && first_ready < 0) first_ready = edge_cnt + 1;
            bit_idx = 3'(7 - pos);
            exp_do  = slot.sym[bit_idx];
            exp_sym = (pos == 0);
            exp_sd  = slot.is_data;
            exp_act = slot.act;
            if (pos == 7) begin
                if (resync) begin
                    slot   = '{IDLE, 1'b0, 1'b0};
                    commas = 1;
                end else if (commas < BC) begin
                    slot   = '{IDLE, 1'b0, 1'b0};
                    commas = commas + 1;
                end else if (valid_in) begin
                    slot = '{data_in, 1'b1, 1'b1};
                end else begin
                    slot = '{IDLE, 1'b0, 1'b1};
                end
            end
            edge_cnt = edge_cnt + 1;
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic v, input logic r);
        data_in  = d;
        valid_in = v;
        resync   = r;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk_8f);
        #1 reset = 1'b1;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_8f);
        #1;
    endtask

    task automatic wait_pos(input int p);
        int guard = 0;
        do begin
            @(posedge clk_8f);
            #1;
            guard++;
        end while ((edge_cnt % 8) != p && guard < 16);
        checkOutput("wait_pos_timeout", {31'd0, (guard < 16)}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_edge);
        bit done = 1'b0;
        acc_edge = -1;
        data_in  = b;
        valid_in = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk_8f);
            #1;
            if (data_ready) begin
                acc_edge = edge_cnt;
                done     = 1'b1;
            end
        end
        checkOutput("accept_timeout", {31'd0, done}, 32'd1);
        @(posedge clk_8f);
        #1 valid_in = 1'b0;
    endtask

    task automatic check_comma_seq();
        logic [31:0] got_do, got_sym, got_act;
        for (int i = 1; i <= 32; i++) begin
            got_do[32-i]  = cap_do[i];
            got_sym[32-i] = cap_sym[i];
            got_act[32-i] = cap_act[i];
        end
        checkOutput("comma_bits", got_do, 32'hBCBCBCBC);
        checkOutput("comma_sym_start", got_sym, 32'h80808080);
        checkOutput("comma_active_low", got_act, 32'h0);
        checkOutput("active_rise_edge33", {31'd0, cap_act[33]}, 32'd1);
        checkOutput("first_ready_edge", first_ready, 32);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, acc_b;
        int b_edge;
        logic [7:0] got8, sd8;
        logic last_acc;

        // Scenario 1: comma preamble with no traffic.
        applyStimulus(8'h00, 1'b0, 1'b0);
        do_reset();
        wait_edges(48);
        check_comma_seq();

        // Scenario 2: byte waiting from release lands in the first active slot.
        applyStimulus(8'hA5, 1'b1, 1'b0);
        do_reset();
        wait_edges(32);
        valid_in = 1'b0;
        wait_edges(20);
        for (int i = 0; i < 8; i++) begin
            got8[7-i] = cap_do[33+i];
            sd8[7-i]  = cap_sd[33+i];
        end
        checkOutput("a5_bits", {24'd0, got8}, 32'hA5);
        checkOutput("a5_sending_data", {24'd0, sd8}, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            got8[7-i] = cap_do[41+i];
            sd8[7-i]  = cap_sd[41+i];
        end
        checkOutput("idle_after_a5", {24'd0, got8}, 32'hBC);
        checkOutput("idle_sending_data", {24'd0, sd8}, 32'h00);

        // Scenario 3: back-to-back bytes, including one equal to the idle symbol.
        send_byte(8'hFF, acc);
        send_byte(8'h00, acc_b);
        checkOutput("b2b_spacing_1", acc_b - acc, 8);
        send_byte(8'hBC, acc);
        checkOutput("b2b_spacing_2", acc - acc_b, 8);
        wait_edges(16);
        for (int i = 0; i < 8; i++) begin
            got8[7-i] = cap_do[acc+1+i];
            sd8[7-i]  = cap_sd[acc+1+i];
        end
        checkOutput("bc_as_data_bits", {24'd0, got8}, 32'hBC);
        checkOutput("bc_as_data_sd", {24'd0, sd8}, 32'hFF);

        // Scenario 4: mid-slot resync pulse is ignored.
        wait_pos(3);
        resync = 1'b1;
        wait_edges(1);
        resync = 1'b0;
        send_byte(8'h5A, acc);
        wait_edges(10);
        checkOutput("after_midslot_resync_active", {31'd0, cap_act[acc+1]}, 32'd1);

        // Scenario 5: resync held across a boundary blocks the pending byte.
        wait_pos(2);
        applyStimulus(8'h3C, 1'b1, 1'b1);
        wait_pos(0);
        b_edge = edge_cnt;
        resync = 1'b0;
        send_byte(8'h3C, acc);
        checkOutput("resync_accept_edge", acc, b_edge + 32);
        wait_edges(12);
        checkOutput("resync_first_slot_inactive", {31'd0, cap_act[b_edge+1]}, 32'd0);
        checkOutput("resync_last_slot_inactive", {31'd0, cap_act[b_edge+32]}, 32'd0);
        checkOutput("resync_data_active", {31'd0, cap_act[b_edge+33]}, 32'd1);
        checkOutput("resync_data_msb", {31'd0, cap_do[b_edge+33]}, 32'd0);
        checkOutput("resync_data_bit5", {31'd0, cap_do[b_edge+35]}, 32'd1);

        // Scenario 6: reset in the middle of a data slot.
        send_byte(8'hFF, acc);
        wait_pos(4);
        reset = 1'b0;
        #1;
        checkOutput("midreset_data_out", {31'd0, data_out}, 32'd0);
        checkOutput("midreset_active", {31'd0, active}, 32'd0);
        checkOutput("midreset_sending_data", {31'd0, sending_data}, 32'd0);
        checkOutput("midreset_sym_start", {31'd0, sym_start}, 32'd0);
        repeat (3) @(posedge clk_8f);
        #1 reset = 1'b1;
        wait_edges(40);
        check_comma_seq();

        // Randomized traffic, with valid held until accepted.
        applyStimulus(8'h00, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_8f);
            #1 last_acc = data_ready && valid_in;
            @(posedge clk_8f);
            #1;
            if (!valid_in || last_acc) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = 8'($urandom);
            end
            resync = ($urandom_range(0, 60) == 0);
            if (c == 1200) begin
                reset = 1'b0;
                wait_edges(2);
                reset = 1'b1;
            end
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        wait_edges(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
